// File: rtl/laser_driver.sv
// laser_driver: host-side companion for one LASER coverage engine.
// Buffers a 40-point frame, streams it into the engine as the engine
// leaves reset, then waits for DONE (bounded by TIMEOUT). It captures
// the two circle centres, optionally re-scores them against the
// stored frame, and reports the result with a one-cycle strobe.
// Build option: define LASER_DRIVER_SCORE_EN to build the SCORE state
// and the squared-distance datapath; otherwise o_score is tied to 0.
// Ports:
//   i_clk, i_rst             clock, async active-high reset
//   i_ld_valid, o_ld_ready   load handshake (ready only in IDLE)
//   i_ld_x, i_ld_y           load point coordinates
//   o_l_rst, o_l_x, o_l_y    engine reset and point stream
//   i_l_done, i_l_c*         engine completion and circle centres
//   o_res_valid, o_res_c*    result strobe and captured centres
//   o_score, o_lat, o_err    covered count, WAIT cycles, timeout flag
//   o_busy                   high in any state other than IDLE
module laser_driver #(
   parameter int TIMEOUT = 1023
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic [3:0]  i_ld_x,
   input  logic [3:0]  i_ld_y,
   output logic        o_l_rst,
   output logic [3:0]  o_l_x,
   output logic [3:0]  o_l_y,
   input  logic        i_l_done,
   input  logic [3:0]  i_l_c1x,
   input  logic [3:0]  i_l_c1y,
   input  logic [3:0]  i_l_c2x,
   input  logic [3:0]  i_l_c2y,
   output logic        o_res_valid,
   output logic [3:0]  o_res_c1x,
   output logic [3:0]  o_res_c1y,
   output logic [3:0]  o_res_c2x,
   output logic [3:0]  o_res_c2y,
   output logic [5:0]  o_score,
   output logic [15:0] o_lat,
   output logic        o_err,
   output logic        o_busy
);

   localparam logic [15:0] LP_TMO  = 16'(TIMEOUT);
   localparam logic [5:0]  LP_LAST = 6'd39;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT,
`ifdef LASER_DRIVER_SCORE_EN
      S_SCORE,
`endif
      S_REPORT
   } state_t;

   state_t      r_state;
   state_t      w_nstate;
   logic [5:0]  r_wcnt;
   logic [5:0]  r_rcnt;
   logic [5:0]  w_rnext;
   logic [7:0]  r_buf [40];
   logic [15:0] r_lat;
   logic [15:0] w_lat_inc;
   logic        w_load;
   logic        w_start;
   logic        w_done;
   logic        w_tmo;

   logic        r_ld_ready;
   logic        r_l_rst;
   logic [3:0]  r_l_x;
   logic [3:0]  r_l_y;
   logic        r_res_valid;
   logic [3:0]  r_c1x;
   logic [3:0]  r_c1y;
   logic [3:0]  r_c2x;
   logic [3:0]  r_c2y;
   logic        r_err;
   logic        r_busy;

   assign w_load    = (r_state == S_IDLE) && i_ld_valid;
   assign w_start   = (r_state == S_IDLE) && (w_nstate == S_STREAM);
   assign w_lat_inc = (r_lat == 16'hFFFF) ? r_lat : r_lat + 16'd1;
   assign w_done    = (r_state == S_WAIT) && i_l_done;
   // DONE wins over a timeout landing on the same cycle
   assign w_tmo     = (r_state == S_WAIT) && !i_l_done
                      && (w_lat_inc == LP_TMO);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nstate;
      end
   end

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_load && (r_wcnt == LP_LAST)) begin
               w_nstate = S_STREAM;
            end
         end
         S_STREAM: begin
            if (r_rcnt == LP_LAST) begin
               w_nstate = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_done) begin
`ifdef LASER_DRIVER_SCORE_EN
               w_nstate = S_SCORE;
`else
               w_nstate = S_REPORT;
`endif
            end else if (w_tmo) begin
               w_nstate = S_REPORT;
            end
         end
`ifdef LASER_DRIVER_SCORE_EN
         S_SCORE: begin
            if (r_rcnt == LP_LAST) begin
               w_nstate = S_REPORT;
            end
         end
`endif
         S_REPORT: begin
            w_nstate = S_IDLE;
         end
         default: begin
            w_nstate = S_IDLE;
         end
      endcase
      // read pointer restarts on every state entry
      w_rnext = (w_nstate == r_state) ? r_rcnt + 6'd1 : 6'd0;
   end

   always_ff @(posedge i_clk) begin
      if (w_load) begin
         r_buf[r_wcnt] <= {i_ld_x, i_ld_y};
      end
   end

   // outputs are registered from the next state so that L_RST drops
   // in the very cycle entry 0 appears on L_X/L_Y
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wcnt      <= 6'd0;
         r_rcnt      <= 6'd0;
         r_ld_ready  <= 1'b1;
         r_l_rst     <= 1'b1;
         r_l_x       <= 4'd0;
         r_l_y       <= 4'd0;
         r_res_valid <= 1'b0;
         r_c1x       <= 4'd0;
         r_c1y       <= 4'd0;
         r_c2x       <= 4'd0;
         r_c2y       <= 4'd0;
         r_lat       <= 16'd0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_ld_ready  <= (w_nstate == S_IDLE);
         r_busy      <= (w_nstate != S_IDLE);
         r_l_rst     <= (w_nstate != S_STREAM) && (w_nstate != S_WAIT);
         r_res_valid <= (w_nstate == S_REPORT);
         r_rcnt      <= w_rnext;
         if (w_load) begin
            r_wcnt <= (r_wcnt == LP_LAST) ? 6'd0 : r_wcnt + 6'd1;
         end
         if (w_nstate == S_STREAM) begin
            r_l_x <= r_buf[w_rnext][7:4];
            r_l_y <= r_buf[w_rnext][3:0];
         end else begin
            r_l_x <= 4'd0;
            r_l_y <= 4'd0;
         end
         if (w_start) begin
            r_lat <= 16'd0;
            r_err <= 1'b0;
         end else if (r_state == S_WAIT) begin
            r_lat <= w_lat_inc;
         end
         if (w_done) begin
            r_c1x <= i_l_c1x;
            r_c1y <= i_l_c1y;
            r_c2x <= i_l_c2x;
            r_c2y <= i_l_c2y;
         end else if (w_tmo) begin
            r_c1x <= 4'd0;
            r_c1y <= 4'd0;
            r_c2x <= 4'd0;
            r_c2y <= 4'd0;
            r_err <= 1'b1;
         end
      end
   end

`ifdef LASER_DRIVER_SCORE_EN
   logic [5:0] r_score;
   logic [7:0] w_pt;
   logic       w_cov;

   function automatic logic [3:0] f_abs(
      input logic [3:0] a,
      input logic [3:0] b
   );
      return (a > b) ? a - b : b - a;
   endfunction

   // widened to 9 bits before squaring so 15*15+15*15 cannot wrap
   function automatic logic f_in(
      input logic [7:0] p,
      input logic [3:0] cx,
      input logic [3:0] cy
   );
      logic [8:0] dx;
      logic [8:0] dy;
      dx = {5'd0, f_abs(p[7:4], cx)};
      dy = {5'd0, f_abs(p[3:0], cy)};
      return (dx * dx + dy * dy) <= 9'd16;
   endfunction

   assign w_pt  = r_buf[r_rcnt];
   assign w_cov = f_in(w_pt, r_c1x, r_c1y) || f_in(w_pt, r_c2x, r_c2y);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_score <= 6'd0;
      end else if (w_start) begin
         r_score <= 6'd0;
      end else if ((r_state == S_SCORE) && w_cov) begin
         r_score <= r_score + 6'd1;
      end
   end

   assign o_score = r_score;
`else
   assign o_score = 6'd0;
`endif

   assign o_ld_ready  = r_ld_ready;
   assign o_l_rst     = r_l_rst;
   assign o_l_x       = r_l_x;
   assign o_l_y       = r_l_y;
   assign o_res_valid = r_res_valid;
   assign o_res_c1x   = r_c1x;
   assign o_res_c1y   = r_c1y;
   assign o_res_c2x   = r_c2x;
   assign o_res_c2y   = r_c2y;
   assign o_lat       = r_lat;
   assign o_err       = r_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_laser_driver.sv
// tb_laser_driver: directed frames against a cycle-level frame model.
// Model tracks phase-by-phase expectations from frame arithmetic.
module tb_laser_driver;

   localparam int TMO = 50;
`ifdef LASER_DRIVER_SCORE_EN
   localparam int SEN = 1;
`else
   localparam int SEN = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0;
   logic [3:0]  ld_x = 4'd0;
   logic [3:0]  ld_y = 4'd0;
   logic        l_done = 1'b0;
   logic [3:0]  lc1x = 4'd0;
   logic [3:0]  lc1y = 4'd0;
   logic [3:0]  lc2x = 4'd0;
   logic [3:0]  lc2y = 4'd0;
   logic        o_ld_ready, o_l_rst, o_res_valid, o_err, o_busy;
   logic [3:0]  o_l_x, o_l_y;
   logic [3:0]  o_res_c1x, o_res_c1y, o_res_c2x, o_res_c2y;
   logic [5:0]  o_score;
   logic [15:0] o_lat;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   bit so_chk = 1'b0;
   int hs = 0;
   int ex_rdy = 1, ex_lrst = 1, ex_lx = 0, ex_ly = 0, ex_rv = 0;
   int m_c1x = 0, m_c1y = 0, m_c2x = 0, m_c2y = 0;
   int m_score = 0, m_lat = 0, m_err = 0;
   int fx [40];
   int fy [40];
   int cc1x, cc1y, cc2x, cc2y;

   laser_driver #(.TIMEOUT(TMO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_ld_valid(ld_valid), .o_ld_ready(o_ld_ready),
      .i_ld_x(ld_x), .i_ld_y(ld_y),
      .o_l_rst(o_l_rst), .o_l_x(o_l_x), .o_l_y(o_l_y),
      .i_l_done(l_done),
      .i_l_c1x(lc1x), .i_l_c1y(lc1y),
      .i_l_c2x(lc2x), .i_l_c2y(lc2y),
      .o_res_valid(o_res_valid),
      .o_res_c1x(o_res_c1x), .o_res_c1y(o_res_c1y),
      .o_res_c2x(o_res_c2x), .o_res_c2y(o_res_c2y),
      .o_score(o_score), .o_lat(o_lat),
      .o_err(o_err), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && ld_valid && o_ld_ready) hs++;
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ld_ready", int'(o_ld_ready), ex_rdy);
         chk("busy", int'(o_busy), 1 - ex_rdy);
         chk("l_rst", int'(o_l_rst), ex_lrst);
         chk("l_x", int'(o_l_x), ex_lx);
         chk("l_y", int'(o_l_y), ex_ly);
         chk("res_valid", int'(o_res_valid), ex_rv);
         chk("res_c1x", int'(o_res_c1x), m_c1x);
         chk("res_c1y", int'(o_res_c1y), m_c1y);
         chk("res_c2x", int'(o_res_c2x), m_c2x);
         chk("res_c2y", int'(o_res_c2y), m_c2y);
         chk("score", int'(o_score), m_score);
         chk("lat", int'(o_lat), m_lat);
         chk("err", int'(o_err), m_err);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input int rdy, input int lrst,
                         input int lx, input int ly, input int rv);
      ex_rdy = rdy;
      ex_lrst = lrst;
      ex_lx = lx;
      ex_ly = ly;
      ex_rv = rv;
   endtask

   task automatic garb();
      lc1x = 4'($urandom);
      lc1y = 4'($urandom);
      lc2x = 4'($urandom);
      lc2y = 4'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         set_ex(1, 1, 0, 0, 0);
      end
   endtask

   function automatic int in_c(int x, int y, int cx, int cy);
      return ((x - cx) * (x - cx) + (y - cy) * (y - cy) <= 16) ? 1 : 0;
   endfunction

   function automatic int pt_cov(int k);
      return (in_c(fx[k], fy[k], cc1x, cc1y) == 1
              || in_c(fx[k], fy[k], cc2x, cc2y) == 1) ? 1 : 0;
   endfunction

   // entered at the start of an IDLE cycle; returns in the REPORT
   // cycle (or in the first IDLE cycle after an abort reset)
   task automatic run_frame(input int done_at, input int abort_at,
                            input bit hold, input bit noise);
      int w;
      bit tmo;
      tmo = 1'b0;
      for (int i = 0; i < 40; i++) begin
         set_ex(1, 1, 0, 0, 0);
         ld_valid = 1'b1;
         ld_x = 4'(fx[i]);
         ld_y = 4'(fy[i]);
         garb();
         cyc();
      end
      ld_valid = hold;
      m_score = 0;
      m_lat = 0;
      m_err = 0;
      for (int i = 0; i < 40; i++) begin
         set_ex(0, 0, fx[i], fy[i], 0);
         if (so_chk && i == 0) chk("so_lrst0", int'(o_l_rst), 0);
         if (so_chk && i == 39) begin
            chk("so_x39", int'(o_l_x), 7);
            chk("so_y39", int'(o_l_y), 2);
         end
         l_done = noise;
         if (hold) begin
            ld_x = 4'(i);
            ld_y = 4'(i + 3);
         end
         garb();
         cyc();
      end
      l_done = 1'b0;
      w = 0;
      forever begin
         m_lat = w;
         set_ex(0, 0, 0, 0, 0);
         garb();
         if (w == abort_at) begin
            rst = 1'b1;
            #1;
            chk("arst_lrst", int'(o_l_rst), 1);
            chk("arst_busy", int'(o_busy), 0);
            chk("arst_ready", int'(o_ld_ready), 1);
            chk("arst_c1x", int'(o_res_c1x), 0);
            chk("arst_lat", int'(o_lat), 0);
            m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
            m_lat = 0; m_score = 0; m_err = 0;
            set_ex(1, 1, 0, 0, 0);
            cyc();
            rst = 1'b0;
            return;
         end
         if (w == done_at) begin
            l_done = 1'b1;
            lc1x = 4'(cc1x);
            lc1y = 4'(cc1y);
            lc2x = 4'(cc2x);
            lc2y = 4'(cc2y);
            cyc();
            l_done = 1'b0;
            garb();
            m_c1x = cc1x; m_c1y = cc1y;
            m_c2x = cc2x; m_c2y = cc2y;
            m_lat = w + 1;
            break;
         end
         if (w + 1 == TMO) begin
            cyc();
            m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
            m_err = 1;
            m_lat = TMO;
            tmo = 1'b1;
            break;
         end
         cyc();
         w++;
      end
      if (SEN == 1 && !tmo) begin
         for (int k = 0; k < 40; k++) begin
            set_ex(0, 1, 0, 0, 0);
            l_done = noise;
            cyc();
            m_score += pt_cov(k);
         end
         l_done = 1'b0;
      end
      set_ex(0, 1, 0, 0, 1);
   endtask

   initial begin
      int hs0;
      repeat (3) cyc();
      chk("rst_lrst", int'(o_l_rst), 1);
      chk("rst_ready", int'(o_ld_ready), 1);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_rv", int'(o_res_valid), 0);
      chk("rst_lat", int'(o_lat), 0);
      rst = 1'b0;
      set_ex(1, 1, 0, 0, 0);
      chk_en = 1'b1;
      idle(2);

      for (int i = 0; i < 10; i++) begin
         ld_valid = 1'b1;
         ld_x = 4'hF;
         ld_y = 4'hF;
         cyc();
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("prst_ready", int'(o_ld_ready), 1);
      cyc();
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 40; i++) begin
         fx[i] = i % 16;
         fy[i] = i / 16;
      end
      cc1x = 2; cc1y = 1; cc2x = 9; cc2y = 2;
      so_chk = 1'b1;
      run_frame(3, -1, 1'b0, 1'b1);
      so_chk = 1'b0;
      chk("so_lat", int'(o_lat), 4);
      chk("so_c2x", int'(o_res_c2x), 9);
      chk("so_score", int'(o_score), SEN * 34);
      idle(2);

      for (int i = 0; i < 40; i++) begin
         fx[i] = 5;
         fy[i] = 5;
      end
      cc1x = 5; cc1y = 5; cc2x = 0; cc2y = 0;
      run_frame(9, -1, 1'b0, 1'b0);
      chk("nom_rv", int'(o_res_valid), 1);
      chk("nom_c1x", int'(o_res_c1x), 5);
      chk("nom_c1y", int'(o_res_c1y), 5);
      chk("nom_lat", int'(o_lat), 10);
      chk("nom_err", int'(o_err), 0);
      chk("nom_score", int'(o_score), SEN * 40);
      idle(1);
      chk("nom_rv_once", int'(o_res_valid), 0);
      idle(1);

      for (int i = 0; i < 40; i++) begin
         fx[i] = 3;
         fy[i] = 3;
      end
      run_frame(-1, 5, 1'b0, 1'b0);
      idle(2);

      for (int i = 0; i < 40; i++) begin
         fx[i] = (i < 20) ? 11 : 12;
         fy[i] = (i < 20) ? 10 : 9;
      end
      cc1x = 8; cc1y = 8; cc2x = 0; cc2y = 15;
      run_frame(0, -1, 1'b0, 1'b0);
      chk("bnd_score", int'(o_score), SEN * 20);
      chk("bnd_lat", int'(o_lat), 1);
      idle(2);

      run_frame(-1, -1, 1'b0, 1'b0);
      chk("tmo_rv", int'(o_res_valid), 1);
      chk("tmo_err", int'(o_err), 1);
      chk("tmo_lat", int'(o_lat), 50);
      chk("tmo_c1x", int'(o_res_c1x), 0);
      chk("tmo_c2y", int'(o_res_c2y), 0);
      idle(2);

      hs0 = hs;
      for (int i = 0; i < 40; i++) begin
         fx[i] = (i * 3) % 16;
         fy[i] = (i * 5) % 16;
      end
      cc1x = 6; cc1y = 9; cc2x = 12; cc2y = 3;
      run_frame(2, -1, 1'b1, 1'b0);
      chk("bp_beats", hs - hs0, 40);
      idle(1);
      for (int i = 0; i < 40; i++) begin
         fx[i] = 15 - (i % 16);
         fy[i] = i % 9;
      end
      cc1x = 10; cc1y = 4; cc2x = 1; cc2y = 7;
      run_frame(1, -1, 1'b0, 1'b0);
      chk("bp_beats2", hs - hs0, 80);
      idle(3);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
